l2_port_arbiter: RTL and testbench

//  Shares one 128-bit block-memory port between the I-cache and D-cache miss/writeback paths.

---
 rtl/l2_port_arbiter.sv | 130 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares one block-memory port between the I-cache and D-cache.
// One request is granted at a time. The winner's command is latched and one memory
// transaction runs. The winner then gets a single-cycle ready pulse.
// Contested grants go to the preferred side, but a bounded streak rule stops the
// other side from starving.
//
//   state  | meaning
//   IDLE   | waiting for a request; arbitration and command latch happen here
//   GNT_I  | I-side transaction on the memory port, waiting for mem_ready
//   GNT_D  | D-side transaction on the memory port, waiting for mem_ready
//   DONE_I | Icache_ready pulse, memory strobes low
//   DONE_D | Dcache_ready pulse, memory strobes low
module l2_port_arbiter #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 128,
   parameter int D_PRIORITY = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              proc_reset_n,
   input  logic              Icache_read,
   input  logic              Icache_write,
   input  logic [ADDR_W-1:0] Icache_addr,
   input  logic [DATA_W-1:0] Icache_wdata,
   output logic              Icache_ready,
   output logic [DATA_W-1:0] Icache_rdata,
   input  logic              Dcache_read,
   input  logic              Dcache_write,
   input  logic [ADDR_W-1:0] Dcache_addr,
   input  logic [DATA_W-1:0] Dcache_wdata,
   output logic              Dcache_ready,
   output logic [DATA_W-1:0] Dcache_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [2:0] {IDLE, GNT_I, GNT_D, DONE_I, DONE_D} state_t;

   localparam logic       PREF_D     = (D_PRIORITY != 0);
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t              state, state_nxt;
   logic                op_write;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_i_q, rdata_d_q;
   logic [2:0]          streak;
   logic                last_d;      // 1: last grant went to the D side
   logic                req_i, req_d, contested, pick_d, starved, grant;

   assign req_i     = Icache_read | Icache_write;
   assign req_d     = Dcache_read | Dcache_write;
   assign contested = req_i & req_d;
   assign grant     = (state == IDLE) & (req_i | req_d);

   // Arbitration: the preferred side wins a contest unless it has already held a long enough streak
   always_comb begin
      starved = 1'b0;
      pick_d  = req_d;
      if (contested) begin
         starved = (last_d == PREF_D) && (streak >= STARVE_LIM);
         pick_d  = starved ? ~PREF_D : PREF_D;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant) state_nxt = pick_d ? GNT_D : GNT_I;
         GNT_I:   if (mem_ready) state_nxt = DONE_I;
         GNT_D:   if (mem_ready) state_nxt = DONE_D;
         DONE_I,
         DONE_D:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) state <= IDLE;
      else               state <= state_nxt;
   end

   // Command latch, streak tracking and read-data capture
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         op_write  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_i_q <= '0;
         rdata_d_q <= '0;
         streak    <= 3'd0;
         last_d    <= 1'b0;
      end else begin
         if (grant) begin
            // a request with both read and write high performs the write
            op_write <= pick_d ? Dcache_write : Icache_write;
            addr_q   <= pick_d ? Dcache_addr  : Icache_addr;
            wdata_q  <= pick_d ? Dcache_wdata : Icache_wdata;
            last_d   <= pick_d;
            if (!contested)
               streak <= 3'd0;
            else if (pick_d == last_d)
               streak <= (streak == 3'd7) ? 3'd7 : streak + 3'd1;
            else
               streak <= 3'd1;
         end
         if (state == GNT_I && mem_ready) rdata_i_q <= mem_rdata;
         if (state == GNT_D && mem_ready) rdata_d_q <= mem_rdata;
      end
   end

   // Port outputs derived from state and latched command
   always_comb begin
      mem_read     = (state == GNT_I || state == GNT_D) && !op_write;
      mem_write    = (state == GNT_I || state == GNT_D) &&  op_write;
      mem_addr     = addr_q;
      mem_wdata    = wdata_q;
      Icache_ready = (state == DONE_I);
      Dcache_ready = (state == DONE_D);
      Icache_rdata = rdata_i_q;
      Dcache_rdata = rdata_d_q;
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter. A transaction-level reference model tracks the pending
// requests of each side and the fairness history. From these it predicts the grant
// order, the memory command and the data that is returned.
module tb_l2_port_arbiter;

   localparam int STARVE = 4;

   logic         clk = 1'b0;
   logic         proc_reset_n;
   logic         Icache_read, Icache_write, Dcache_read, Dcache_write;
   logic [27:0]  Icache_addr, Dcache_addr, mem_addr;
   logic [127:0] Icache_wdata, Dcache_wdata, Icache_rdata, Dcache_rdata;
   logic [127:0] mem_wdata, mem_rdata;
   logic         Icache_ready, Dcache_ready, mem_read, mem_write, mem_ready;

   l2_port_arbiter #(.ADDR_W(28), .DATA_W(128), .D_PRIORITY(1), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .proc_reset_n(proc_reset_n),
      .Icache_read(Icache_read), .Icache_write(Icache_write), .Icache_addr(Icache_addr),
      .Icache_wdata(Icache_wdata), .Icache_ready(Icache_ready), .Icache_rdata(Icache_rdata),
      .Dcache_read(Dcache_read), .Dcache_write(Dcache_write), .Dcache_addr(Dcache_addr),
      .Dcache_wdata(Dcache_wdata), .Dcache_ready(Dcache_ready), .Dcache_rdata(Dcache_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model: pending requests per side (0 = I, 1 = D) and fairness history
   bit           pend [2];
   logic [1:0]   op   [2];      // bit0 read, bit1 write
   logic [27:0]  addr [2];
   logic [127:0] wd   [2];
   logic [127:0] exp_rd [2];
   logic [27:0]  exp_addr;
   logic [127:0] exp_wdata;
   int           last_w, streak;
   bit           mr_tie;
   int           obs_w;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic drive_inputs();
      Icache_read  = pend[0] & op[0][0];
      Icache_write = pend[0] & op[0][1];
      Icache_addr  = addr[0];
      Icache_wdata = wd[0];
      Dcache_read  = pend[1] & op[1][0];
      Dcache_write = pend[1] & op[1][1];
      Dcache_addr  = addr[1];
      Dcache_wdata = wd[1];
   endtask

   task automatic set_req(input int s, input logic [1:0] o, input logic [27:0] a, input logic [127:0] d);
      pend[s] = 1'b1; op[s] = o; addr[s] = a; wd[s] = d;
   endtask

   task automatic model_reset();
      pend[0] = 0; pend[1] = 0; op[0] = 0; op[1] = 0;
      addr[0] = 0; addr[1] = 0; wd[0] = 0; wd[1] = 0;
      exp_rd[0] = 0; exp_rd[1] = 0; exp_addr = 0; exp_wdata = 0;
      last_w = 0; streak = 0;
   endtask

   // one arbitration round, entered and left in an IDLE cycle
   task automatic round(input int lat, input logic [127:0] rd, input bit scramble);
      int w;
      bit wr, cont;
      drive_inputs();
      if (!pend[0] && !pend[1]) begin
         mem_ready = $urandom_range(1);
         tick();
         chk("idle_strobe", {126'b0, mem_read, mem_write}, 128'd0);
         chk("idle_ready", {126'b0, Icache_ready, Dcache_ready}, 128'd0);
         mem_ready = mr_tie;
         return;
      end
      cont = pend[0] && pend[1];
      if (cont) w = (last_w == 1 && streak >= STARVE) ? 0 : 1;
      else      w = pend[1] ? 1 : 0;
      if (cont) streak = (w == last_w) ? ((streak < 7) ? streak + 1 : 7) : 1;
      else      streak = 0;
      last_w    = w;
      wr        = op[w][1];
      exp_addr  = addr[w];
      exp_wdata = wd[w];
      tick();
      for (int c = 1; c <= lat; c++) begin
         chk("gnt_strobe", {126'b0, mem_read, mem_write}, {126'b0, !wr, wr});
         chk("gnt_addr", {100'b0, mem_addr}, {100'b0, exp_addr});
         chk("gnt_wdata", mem_wdata, exp_wdata);
         chk("gnt_ready", {126'b0, Icache_ready, Dcache_ready}, 128'd0);
         if (scramble) begin
            if (w == 1) begin Dcache_addr = 28'($urandom()); Dcache_wdata = rand128(); end
            else        begin Icache_addr = 28'($urandom()); Icache_wdata = rand128(); end
         end
         mem_ready = (c == lat) || mr_tie;
         mem_rdata = (c == lat) ? rd : rand128();
         tick();
      end
      exp_rd[w] = rd;
      obs_w = Dcache_ready ? 1 : (Icache_ready ? 0 : -1);
      chk("done_ready", {126'b0, Icache_ready, Dcache_ready}, {126'b0, w == 0, w == 1});
      chk("done_strobe", {126'b0, mem_read, mem_write}, 128'd0);
      chk("done_rdata_i", Icache_rdata, exp_rd[0]);
      chk("done_rdata_d", Dcache_rdata, exp_rd[1]);
      pend[w] = 1'b0;
      drive_inputs();
      mem_ready = mr_tie ? 1'b1 : 1'($urandom_range(1));
      mem_rdata = rand128();
      tick();
      chk("idle_ready", {126'b0, Icache_ready, Dcache_ready}, 128'd0);
      chk("idle_strobe", {126'b0, mem_read, mem_write}, 128'd0);
      chk("idle_addr_hold", {100'b0, mem_addr}, {100'b0, exp_addr});
      chk("idle_rdata_hold", Icache_rdata ^ Dcache_rdata, exp_rd[0] ^ exp_rd[1]);
      mem_ready = mr_tie;
   endtask

   int t3_seq [7] = '{1, 1, 1, 1, 0, 1, 1};

   initial begin
      proc_reset_n = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      mr_tie = 1'b0;
      obs_w = -1;
      model_reset();
      drive_inputs();
      repeat (3) tick();
      chk("rst_strobe", {126'b0, mem_read, mem_write}, 128'd0);
      chk("rst_ready", {126'b0, Icache_ready, Dcache_ready}, 128'd0);
      chk("rst_addr", {100'b0, mem_addr}, 128'd0);
      chk("rst_wdata", mem_wdata, 128'd0);
      chk("rst_rdata", Icache_rdata | Dcache_rdata, 128'd0);
      proc_reset_n = 1'b1;
      tick();

      // lone I read, memory answers at cycle 3
      set_req(0, 2'b01, 28'h0000010, rand128());
      round(3, {16{8'hA5}}, 1'b0);
      chk("t1_winner", obs_w, 0);

      // simultaneous I read and D write: D first, then I
      set_req(0, 2'b01, 28'h100, rand128());
      set_req(1, 2'b10, 28'h200, 128'h1234);
      round(2, rand128(), 1'b0);
      chk("t2_first", obs_w, 1);
      round(1, rand128(), 1'b0);
      chk("t2_second", obs_w, 0);

      // D continuous with I held: streak limit hands the fifth grant to I
      for (int r = 0; r < 7; r++) begin
         if (!pend[0]) set_req(0, 2'b01, 28'($urandom()), rand128());
         if (!pend[1]) set_req(1, 2'($urandom_range(1, 3)), 28'($urandom()), rand128());
         round(1 + r % 3, rand128(), 1'b0);
         chk("t3_grant", obs_w, t3_seq[r]);
      end
      pend[0] = 0; pend[1] = 0;

      // requester changes its address while granted
      set_req(0, 2'b01, 28'h40, rand128());
      round(4, rand128(), 1'b1);

      // mem_ready tied high, back-to-back D reads
      mr_tie = 1'b1;
      mem_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         set_req(1, 2'b01, 28'($urandom()), rand128());
         round(1, rand128(), 1'b0);
      end
      mr_tie = 1'b0;
      mem_ready = 1'b0;

      // reset in the middle of a D write
      set_req(1, 2'b10, 28'h3333, rand128());
      drive_inputs();
      tick();
      chk("t5_wr_before", {127'b0, mem_write}, 128'd1);
      proc_reset_n = 1'b0;
      #1;
      chk("t5_wr_async", {127'b0, mem_write}, 128'd0);
      model_reset();
      drive_inputs();
      mem_ready = 1'b1;
      tick();
      chk("t5_no_ready", {126'b0, Icache_ready, Dcache_ready}, 128'd0);
      mem_ready = 1'b0;
      tick();
      proc_reset_n = 1'b1;
      tick();
      chk("t5_strobe", {126'b0, mem_read, mem_write}, 128'd0);
      chk("t5_ready", {126'b0, Icache_ready, Dcache_ready}, 128'd0);
      chk("t5_addr", {100'b0, mem_addr}, 128'd0);
      chk("t5_wdata", mem_wdata, 128'd0);
      chk("t5_rdata", Icache_rdata | Dcache_rdata, 128'd0);

      // randomized traffic
      for (int r = 0; r < 120; r++) begin
         if (!pend[0] && $urandom_range(3) != 0)
            set_req(0, 2'($urandom_range(1, 3)), 28'($urandom()), rand128());
         if (!pend[1] && $urandom_range(3) != 0)
            set_req(1, 2'($urandom_range(1, 3)), 28'($urandom()), rand128());
         round($urandom_range(1, 4), rand128(), 1'($urandom_range(1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
